// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   rx_state_t                : deframer FSM states
//   UART_DATA_BITS            : data bits per character (8N1)
//   UART_DEFAULT_CLKS_PER_BIT : 100 MHz / 115200 baud
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: circular buffer with naturally wrapping pointers.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties the buffer)
//   push, push_data : write request; refused when full unless a pop happens this cycle
//   full            : occupancy == DEPTH
//   pop, pop_data   : read request (ignored when empty); pop_data is the head entry
//   empty           : occupancy == 0
//   count           : current occupancy
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_q, rd_q;
  logic [AW:0]                 cnt_q;
  logic                        do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head comes straight out of the storage flops, so it holds while not popped.
  assign pop_data = mem_q[rd_q];
  assign count    = cnt_q;
endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receive front-end: synchronises rxd, deframes characters at
// mid-bit sample points and queues good bytes in a small FIFO.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   rxd                 : asynchronous serial input, idle high
//   rx_data/rx_valid    : FIFO head and not-empty flag
//   rx_ready            : consumer accept; pop on rx_valid && rx_ready
//   rx_busy             : FSM not in IDLE
//   frame_err           : 1-cycle pulse, stop bit sampled low
//   overrun             : 1-cycle pulse, good byte dropped on a full FIFO
//   fifo_count          : FIFO occupancy
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic [UART_DATA_BITS-1:0]     rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  rx_state_t                 state_q;
  logic [1:0]                sync_q;
  logic                      rxs, rxs_d_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [IDX_W-1:0]          bit_idx_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic                      frame_err_q, overrun_q;
  logic                      cnt_done, push_d, fifo_full, fifo_empty;

  assign rxs      = sync_q[1];
  assign cnt_done = (cnt_q == FULL_M1);
  // Good stop bit: push in the same cycle it is sampled so the byte is
  // visible on the following cycle.
  assign push_d   = (state_q == STOP) && cnt_done && rxs;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b11;
      rxs_d_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      rxs_d_q     <= rxs;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // Edge, not level: a held-low (break) line cannot retrigger.
          if (!rxs && rxs_d_q) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // Line back high at mid start bit is a glitch: drop silently.
            state_q   <= rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_done) begin
            cnt_q     <= '0;
            shreg_q   <= {rxs, shreg_q[UART_DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + IDX_W'(1);
            if (bit_idx_q == LAST_IDX) state_q <= STOP;
          end
        end
        STOP: begin
          if (cnt_done) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!rxs)                       frame_err_q <= 1'b1;
            else if (fifo_full && !rx_ready) overrun_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_d),
    .push_data (shreg_q),
    .full      (fifo_full),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid  = !fifo_empty;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, rxd, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun;
  logic [2:0] fifo_count;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  int n_pop, n_vld, fe_cnt, ov_cnt, fe_run, ov_run, fe_wmax, ov_wmax, both_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic clr_stats();
    n_pop = 0; n_vld = 0; fe_cnt = 0; ov_cnt = 0;
    fe_wmax = 0; ov_wmax = 0; both_cnt = 0;
  endtask

  // Scoreboard side: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) n_vld++;
      if (rx_valid && rx_ready) begin
        n_pop++;
        if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          chk("sb_data", rx_data, mon_e);
        end
      end
      if (frame_err) begin fe_cnt++; fe_run++; end else fe_run = 0;
      if (overrun)   begin ov_cnt++; ov_run++; end else ov_run = 0;
      if (fe_run > fe_wmax) fe_wmax = fe_run;
      if (ov_run > ov_wmax) ov_wmax = ov_run;
      if (frame_err && overrun) both_cnt++;
    end
  end

  // One 8N1 character. With pop_at_stop, rx_ready is high only for the
  // clock edge on which the stop bit is sampled (edge 155 after start).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_at_stop);
    @(posedge clk); #1 rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rxd = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 rxd = stop_bit;
    for (int c = 1; c <= CPB; c++) begin
      @(posedge clk); #1;
      if (pop_at_stop && c == 10) rx_ready = 1'b1;
      if (pop_at_stop && c == 11) rx_ready = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    rx_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_cnt0"}, fifo_count, 0);
  endtask

  initial begin
    reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
    fe_run = 0; ov_run = 0;
    clr_stats();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", rx_data, 0);

    // 1: good frame, consumer always ready
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t1_pops", n_pop, 1);
    chk("t1_vld_cycles", n_vld, 1);
    chk("t1_errs", fe_cnt + ov_cnt, 0);
    chk("t1_busy", rx_busy, 0);

    // 2: short low glitch
    clr_stats();
    @(posedge clk); #1 rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd = 1'b1;
    @(negedge clk);
    chk("t2_busy_mid", rx_busy, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t2_busy", rx_busy, 0);
    chk("t2_vld", n_vld, 0);
    chk("t2_errs", fe_cnt + ov_cnt, 0);

    // 3: bad stop bit, line then held low
    clr_stats();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t3_fe_cnt", fe_cnt, 1);
    chk("t3_fe_width", fe_wmax, 1);
    chk("t3_count", fifo_count, 0);
    chk("t3_busy_break", rx_busy, 0);
    chk("t3_vld", n_vld, 0);
    #1 rxd = 1'b1;
    repeat (5) @(posedge clk);

    // 4: fill, overrun on the fifth byte, then drain in order
    clr_stats();
    #1 rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_count", fifo_count, 4);
    chk("t4_ov_cnt", ov_cnt, 1);
    chk("t4_ov_width", ov_wmax, 1);
    chk("t4_fe_cnt", fe_cnt, 0);
    @(posedge clk); #1;
    drain("t4");
    chk("t4_pops", n_pop, 4);

    // 5: full FIFO, pop exactly on the stop-bit push
    clr_stats();
    #1 rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_full", fifo_count, 4);
    send_frame(8'h15, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_count", fifo_count, 4);
    chk("t5_ov_cnt", ov_cnt, 0);
    chk("t5_pops", n_pop, 1);
    @(posedge clk); #1;
    drain("t5");

    // 6: reset in the middle of DATA with two bytes queued
    clr_stats();
    #1 rx_ready = 1'b0;
    exp_q.push_back(8'h21); exp_q.push_back(8'h22);
    send_frame(8'h21, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_count2", fifo_count, 2);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t6_busy_pre", rx_busy, 1);
    @(posedge clk); #1 reset = 1'b1; rxd = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", rx_busy, 0);
    chk("t6_valid", rx_valid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_data", rx_data, 0);
    clr_stats();
    rx_ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6_pops", n_pop, 1);
    chk("t6_qempty", exp_q.size(), 0);

    chk("never_both", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
